// File: rtl/rom_access_arbiter_pkg.sv
// Shared definitions for the ROM access arbiter.
//   owner_e    : which requester owns an in-flight read (IF = 0, LSU = 1)
//   inflight_t : one latency-pipeline slot {valid, owner, err}
//   addr_fault : misalignment / ROM-window check on a byte address
//   rom_word_index : byte address -> ROM word index relative to the window base
package rom_arb_pkg;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
    } inflight_t;

    // Addresses are widened to 64 bits so one function serves any ADDR_WIDTH
    // up to 64 and the window span (4 * 2^rom_aw) never overflows.
    function automatic logic addr_fault(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input int unsigned rom_aw);
        logic [63:0] off;
        logic [63:0] span;
        off  = addr - base;
        span = 64'd4 << rom_aw;
        return (addr[1:0] != 2'b00) || (addr < base) || (off >= span);
    endfunction

    function automatic logic [63:0] rom_word_index(input logic [63:0] addr,
                                                   input logic [63:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/rom_access_arbiter_if.sv
// Bus bundle between the core-side requesters / ROM and the arbiter.
//   IF port  : if_req_valid/addr/ready, if_flush, if_resp_valid/data/err
//   LSU port : ls_req_valid/addr/ready, ls_resp_valid/data/err
//   ROM port : rom_en, rom_addr, rom_rdata
// slave  : the arbiter's view; master : the core + ROM view.
interface rom_access_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROM_AW     = 10
);
    logic                  if_req_valid;
    logic [ADDR_WIDTH-1:0] if_req_addr;
    logic                  if_req_ready;
    logic                  if_flush;
    logic                  if_resp_valid;
    logic [DATA_WIDTH-1:0] if_resp_data;
    logic                  if_resp_err;

    logic                  ls_req_valid;
    logic [ADDR_WIDTH-1:0] ls_req_addr;
    logic                  ls_req_ready;
    logic                  ls_resp_valid;
    logic [DATA_WIDTH-1:0] ls_resp_data;
    logic                  ls_resp_err;

    logic                  rom_en;
    logic [ROM_AW-1:0]     rom_addr;
    logic [DATA_WIDTH-1:0] rom_rdata;

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
        input  ls_req_valid, ls_req_addr,
        output ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
        output rom_en, rom_addr,
        input  rom_rdata
    );

    modport master (
        output if_req_valid, if_req_addr, if_flush,
        input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
        output ls_req_valid, ls_req_addr,
        input  ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
        input  rom_en, rom_addr,
        output rom_rdata
    );

endinterface

// File: rtl/rom_access_arbiter_inflight_pipe.sv
// Fixed-latency tracker for ROM reads in flight.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : entry for the read issued this cycle (valid=0 if none)
//   kill_i        : per-owner kill mask, bit index = owner encoding
//   head_o        : entry whose response is due this cycle (kill applied)
// Shifts every cycle; a kill clears matching entries both at the head
// (same-cycle suppression) and as they move down the pipe.
module rom_inflight_pipe
    import rom_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  inflight_t push_i,
    input  logic [1:0] kill_i,
    output inflight_t head_o
);

    inflight_t stage_q [DEPTH];
    inflight_t stage_d [DEPTH];

    function automatic inflight_t apply_kill(input inflight_t e, input logic [1:0] kill);
        inflight_t r;
        r = e;
        if ((e.owner == OWNER_IF && kill[0]) || (e.owner == OWNER_LS && kill[1])) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        stage_d[0] = push_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = apply_kill(stage_q[i-1], kill_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign head_o = apply_kill(stage_q[DEPTH-1], kill_i);

endmodule

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between instruction fetch
// (IF) and the load unit (LSU).
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : requester handshakes, IF flush, responses and ROM port
// One read per cycle; faulting requests (misaligned / outside the ROM window)
// never reach the ROM but still take a pipeline slot so responses stay in
// order with a fixed READ_LATENCY.
module rom_access_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ROM_AW       = 10,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE     = '0,
    parameter int unsigned           READ_LATENCY = 1
) (
    input logic                 clk,
    input logic                 reset,
    rom_access_arbiter_if.slave bus
);

    owner_e                rr_q;
    owner_e                rr_d;
    logic                  if_elig;
    logic                  ls_elig;
    logic                  grant_if;
    logic                  grant_ls;
    logic                  grant_any;
    logic                  fault;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    inflight_t             push;
    inflight_t             head;

    // Eligibility is gated by reset so ready/rom_en read 0 while reset is held.
    always_comb begin
        if_elig   = reset && bus.if_req_valid && !bus.if_flush;
        ls_elig   = reset && bus.ls_req_valid;
        grant_if  = if_elig && (!ls_elig || rr_q == OWNER_IF);
        grant_ls  = ls_elig && !grant_if;
        grant_any = grant_if || grant_ls;

        gnt_addr  = grant_ls ? bus.ls_req_addr : bus.if_req_addr;
        fault     = addr_fault(64'(gnt_addr), 64'(ROM_BASE), ROM_AW);

        rr_d = rr_q;
        if (grant_if) begin
            rr_d = OWNER_LS;
        end else if (grant_ls) begin
            rr_d = OWNER_IF;
        end

        push       = '0;
        push.valid = grant_any;
        push.owner = grant_ls ? OWNER_LS : OWNER_IF;
        push.err   = fault;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q <= OWNER_IF;
        end else begin
            rr_q <= rr_d;
        end
    end

    rom_inflight_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_pipe (
        .clk_i  (clk),
        .rst_ni (reset),
        .push_i (push),
        .kill_i ({1'b0, bus.if_flush}),
        .head_o (head)
    );

    assign bus.if_req_ready = grant_if;
    assign bus.ls_req_ready = grant_ls;

    // The ROM only ever sees addresses that passed the window check.
    assign bus.rom_en   = grant_any && !fault;
    assign bus.rom_addr = (grant_any && !fault)
                          ? ROM_AW'(rom_word_index(64'(gnt_addr), 64'(ROM_BASE)))
                          : '0;

    assign bus.if_resp_valid = head.valid && head.owner == OWNER_IF;
    assign bus.if_resp_err   = bus.if_resp_valid && head.err;
    assign bus.if_resp_data  = (bus.if_resp_valid && !head.err) ? bus.rom_rdata : '0;

    assign bus.ls_resp_valid = head.valid && head.owner == OWNER_LS;
    assign bus.ls_resp_err   = bus.ls_resp_valid && head.err;
    assign bus.ls_resp_data  = (bus.ls_resp_valid && !head.err) ? bus.rom_rdata : '0;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: three instances (READ_LATENCY 1, 2, 4) share
// one stimulus stream; each has its own ROM model and a queue-based reference
// model that predicts grants, ROM accesses and time-stamped responses.
module tb_rom_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_v;
    logic        fl;
    logic        ls_v;
    logic [31:0] if_a;
    logic [31:0] ls_a;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic        own;   // 0 = IF, 1 = LSU
        logic        err;
        logic [31:0] data;
        logic        dead;
    } exp_t;

    function automatic logic [31:0] img(input logic [9:0] w);
        return 32'hF00D_0000 | 32'(w);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 2 : 4;

        rom_access_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROM_AW(10)) bus ();

        rom_access_arbiter #(
            .ADDR_WIDTH   (32),
            .DATA_WIDTH   (32),
            .ROM_AW       (10),
            .ROM_BASE     (32'h0000_0000),
            .READ_LATENCY (L)
        ) dut (
            .clk   (clk),
            .reset (rst_n),
            .bus   (bus)
        );

        assign bus.if_req_valid = if_v;
        assign bus.if_req_addr  = if_a;
        assign bus.if_flush     = fl;
        assign bus.ls_req_valid = ls_v;
        assign bus.ls_req_addr  = ls_a;

        // ROM: data for an enabled read shows up L cycles later; idle slots
        // carry junk so a response that should be zero cannot hide.
        logic [31:0] rp [L];
        always @(posedge clk) begin
            for (int i = L - 1; i > 0; i--) rp[i] <= rp[i-1];
            rp[0] <= bus.rom_en ? img(bus.rom_addr) : 32'hDEAD_BEEF;
        end
        assign bus.rom_rdata = rp[L-1];

        exp_t        q[$];
        logic        rr = 1'b0;
        int unsigned cyc = 0;

        always @(negedge clk) begin : model
            logic        ei, el, gi, gl, flt;
            logic [31:0] a;
            exp_t        e;
            logic        xiv, xlv, xie, xle;
            logic [31:0] xid, xld;
            if (!rst_n) begin
                q.delete();
                rr = 1'b0;
                chk($sformatf("L%0d rst if_req_ready", L),  32'(bus.if_req_ready), 0);
                chk($sformatf("L%0d rst ls_req_ready", L),  32'(bus.ls_req_ready), 0);
                chk($sformatf("L%0d rst rom_en", L),        32'(bus.rom_en), 0);
                chk($sformatf("L%0d rst rom_addr", L),      32'(bus.rom_addr), 0);
                chk($sformatf("L%0d rst if_resp_valid", L), 32'(bus.if_resp_valid), 0);
                chk($sformatf("L%0d rst if_resp_data", L),  bus.if_resp_data, 0);
                chk($sformatf("L%0d rst if_resp_err", L),   32'(bus.if_resp_err), 0);
                chk($sformatf("L%0d rst ls_resp_valid", L), 32'(bus.ls_resp_valid), 0);
                chk($sformatf("L%0d rst ls_resp_data", L),  bus.ls_resp_data, 0);
                chk($sformatf("L%0d rst ls_resp_err", L),   32'(bus.ls_resp_err), 0);
            end else begin
                if (fl) foreach (q[i]) if (!q[i].own) q[i].dead = 1'b1;
                xiv = 1'b0; xlv = 1'b0; xie = 1'b0; xle = 1'b0; xid = '0; xld = '0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    if (!e.dead) begin
                        if (e.own) begin xlv = 1'b1; xle = e.err; xld = e.data; end
                        else       begin xiv = 1'b1; xie = e.err; xid = e.data; end
                    end
                end
                chk($sformatf("L%0d if_resp_valid", L), 32'(bus.if_resp_valid), 32'(xiv));
                chk($sformatf("L%0d ls_resp_valid", L), 32'(bus.ls_resp_valid), 32'(xlv));
                if (xiv) begin
                    chk($sformatf("L%0d if_resp_data", L), bus.if_resp_data, xid);
                    chk($sformatf("L%0d if_resp_err", L),  32'(bus.if_resp_err), 32'(xie));
                end
                if (xlv) begin
                    chk($sformatf("L%0d ls_resp_data", L), bus.ls_resp_data, xld);
                    chk($sformatf("L%0d ls_resp_err", L),  32'(bus.ls_resp_err), 32'(xle));
                end

                ei  = if_v && !fl;
                el  = ls_v;
                gi  = ei && (!el || !rr);
                gl  = el && !gi;
                a   = gi ? if_a : ls_a;
                flt = (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
                chk($sformatf("L%0d if_req_ready", L), 32'(bus.if_req_ready), 32'(gi));
                chk($sformatf("L%0d ls_req_ready", L), 32'(bus.ls_req_ready), 32'(gl));
                chk($sformatf("L%0d rom_en", L), 32'(bus.rom_en), 32'((gi || gl) && !flt));
                if ((gi || gl) && !flt)
                    chk($sformatf("L%0d rom_addr", L), 32'(bus.rom_addr), 32'(a[11:2]));
                if (gi || gl) begin
                    q.push_back('{due: cyc + L, own: gl, err: flt,
                                  data: flt ? 32'h0 : img(a[11:2]), dead: 1'b0});
                    rr = gi;
                end
            end
            cyc++;
        end
    end

    // Drive one cycle's inputs just after the rising edge, then return just
    // after the falling edge (after the models have compared).
    task automatic cyc_in(input logic r, input logic iv, input logic [31:0] ia,
                          input logic f, input logic lv, input logic [31:0] la);
        @(posedge clk);
        #1;
        rst_n = r; if_v = iv; if_a = ia; fl = f; ls_v = lv; ls_a = la;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        int unsigned k;
        k = $urandom_range(0, 15);
        if (k == 0) return {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
        if (k == 1) return 32'h0000_1000 + {$urandom_range(0, 255), 2'b00};
        return {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    endfunction

    initial begin : stim
        logic        niv, nlv, nf;
        logic [31:0] nia, nla;
        rst_n = 1'b0; if_v = 1'b0; fl = 1'b0; ls_v = 1'b0; if_a = '0; ls_a = '0;

        cyc_in(0, 1, 32'h0, 0, 1, 32'h0);
        chk("rst if_ready", 32'(lane[0].bus.if_req_ready), 0);
        chk("rst ls_ready", 32'(lane[0].bus.ls_req_ready), 0);
        cyc_in(0, 0, 32'h0, 0, 0, 32'h0);

        // IF-only stream
        cyc_in(1, 1, 32'h0, 0, 0, 32'h0);
        chk("if0 ready", 32'(lane[0].bus.if_req_ready), 1);
        chk("if0 rom_addr", 32'(lane[0].bus.rom_addr), 0);
        cyc_in(1, 1, 32'h4, 0, 0, 32'h0);
        chk("if1 rom_addr", 32'(lane[0].bus.rom_addr), 1);
        chk("if0 resp_data", lane[0].bus.if_resp_data, 32'hF00D_0000);
        cyc_in(1, 1, 32'h8, 0, 0, 32'h0);
        chk("if2 rom_addr", 32'(lane[0].bus.rom_addr), 2);
        chk("if1 resp_data", lane[0].bus.if_resp_data, 32'hF00D_0001);
        cyc_in(1, 0, 32'h0, 0, 1, 32'h20);
        chk("if2 resp_data", lane[0].bus.if_resp_data, 32'hF00D_0002);

        // Contention, pointer at IF
        cyc_in(1, 1, 32'h40, 0, 1, 32'h80);
        chk("ct0 if_ready", 32'(lane[0].bus.if_req_ready), 1);
        chk("ct0 ls_ready", 32'(lane[0].bus.ls_req_ready), 0);
        chk("ls20 resp_data", lane[0].bus.ls_resp_data, 32'hF00D_0008);
        cyc_in(1, 1, 32'h44, 0, 1, 32'h80);
        chk("ct1 if_ready", 32'(lane[0].bus.if_req_ready), 0);
        chk("ct1 rom_addr", 32'(lane[0].bus.rom_addr), 32'h20);
        chk("ct1 if_resp_data", lane[0].bus.if_resp_data, 32'hF00D_0010);
        cyc_in(1, 1, 32'h44, 0, 1, 32'h84);
        chk("ct2 rom_addr", 32'(lane[0].bus.rom_addr), 32'h11);
        chk("ct2 ls_resp_data", lane[0].bus.ls_resp_data, 32'hF00D_0020);
        cyc_in(1, 1, 32'h48, 0, 1, 32'h84);
        chk("ct3 ls_ready", 32'(lane[0].bus.ls_req_ready), 1);
        chk("ct3 if_resp_data", lane[0].bus.if_resp_data, 32'hF00D_0011);

        // Faults and window edge
        cyc_in(1, 0, 32'h0, 0, 1, 32'h6);
        chk("mis rom_en", 32'(lane[0].bus.rom_en), 0);
        chk("mis ls_ready", 32'(lane[0].bus.ls_req_ready), 1);
        cyc_in(1, 1, 32'h1000, 0, 0, 32'h0);
        chk("oow rom_en", 32'(lane[0].bus.rom_en), 0);
        chk("mis ls_resp_err", 32'(lane[0].bus.ls_resp_err), 1);
        chk("mis ls_resp_data", lane[0].bus.ls_resp_data, 0);
        cyc_in(1, 1, 32'hFFC, 0, 0, 32'h0);
        chk("top rom_addr", 32'(lane[0].bus.rom_addr), 32'h3FF);
        chk("oow if_resp_err", 32'(lane[0].bus.if_resp_err), 1);
        cyc_in(1, 0, 32'h0, 0, 0, 32'h0);
        chk("top if_resp_data", lane[0].bus.if_resp_data, 32'hF00D_03FF);

        // Flush with two IF reads in flight (checked on the latency-2 lane)
        cyc_in(1, 1, 32'h10, 0, 0, 32'h0);
        cyc_in(1, 1, 32'h14, 0, 0, 32'h0);
        cyc_in(1, 1, 32'h18, 1, 1, 32'h30);
        chk("fl L2 ls_ready", 32'(lane[1].bus.ls_req_ready), 1);
        chk("fl L2 if_ready", 32'(lane[1].bus.if_req_ready), 0);
        chk("fl L2 if_resp_valid a", 32'(lane[1].bus.if_resp_valid), 0);
        chk("fl L1 same-cycle kill", 32'(lane[0].bus.if_resp_valid), 0);
        cyc_in(1, 0, 32'h0, 0, 0, 32'h0);
        chk("fl L2 if_resp_valid b", 32'(lane[1].bus.if_resp_valid), 0);
        cyc_in(1, 0, 32'h0, 0, 0, 32'h0);
        chk("fl L2 ls_resp_valid", 32'(lane[1].bus.ls_resp_valid), 1);
        chk("fl L2 ls_resp_data", lane[1].bus.ls_resp_data, 32'hF00D_000C);

        // Flush with both valid while the pointer favours IF
        cyc_in(1, 1, 32'h18, 1, 1, 32'h34);
        chk("flp if_ready", 32'(lane[0].bus.if_req_ready), 0);
        chk("flp ls_ready", 32'(lane[0].bus.ls_req_ready), 1);
        cyc_in(1, 1, 32'h18, 0, 0, 32'h0);
        chk("flp next if_ready", 32'(lane[0].bus.if_req_ready), 1);

        // Reset with reads pending on the latency-4 lane
        cyc_in(1, 1, 32'h20, 0, 0, 32'h0);
        cyc_in(1, 0, 32'h0, 0, 1, 32'h24);
        cyc_in(0, 1, 32'h28, 0, 1, 32'h2C);
        chk("mrst L4 if_ready", 32'(lane[2].bus.if_req_ready), 0);
        chk("mrst L4 rom_en", 32'(lane[2].bus.rom_en), 0);
        cyc_in(0, 1, 32'h28, 0, 1, 32'h2C);
        for (int k = 0; k < 5; k++) begin
            cyc_in(1, 0, 32'h0, 0, 0, 32'h0);
            chk("mrst L4 stale if", 32'(lane[2].bus.if_resp_valid), 0);
            chk("mrst L4 stale ls", 32'(lane[2].bus.ls_resp_valid), 0);
        end
        cyc_in(1, 1, 32'h30, 0, 1, 32'h40);
        chk("mrst first if_ready", 32'(lane[2].bus.if_req_ready), 1);
        chk("mrst first ls_ready", 32'(lane[2].bus.ls_req_ready), 0);

        // Mixed random traffic; requesters hold until accepted
        for (int k = 0; k < 400; k++) begin
            niv = if_v; nia = if_a; nlv = ls_v; nla = ls_a;
            if (!(if_v && !lane[0].bus.if_req_ready)) begin
                niv = ($urandom_range(0, 9) < 6);
                nia = rnd_addr();
            end
            if (!(ls_v && !lane[0].bus.ls_req_ready)) begin
                nlv = ($urandom_range(0, 9) < 6);
                nla = rnd_addr();
            end
            nf = ($urandom_range(0, 15) == 0);
            cyc_in(1, niv, nia, nf, nlv, nla);
        end
        for (int k = 0; k < 6; k++) cyc_in(1, 0, 32'h0, 0, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
